nx_fifo_rd_prefetch: RTL and testbench

//   Read-side consumer for the nx_fifo_ctrl family. Issues ren to the FIFO controller while the FIFO
//   is non-empty, absorbs the storage RAM read latency, and presents entries as a valid/ready stream.
//   A DEPTH-entry prefetch buffer with credit accounting means back-pressure never drops in-flight data.

---
 rtl/nx_fifo_rd_prefetch.sv | 109 ++++++++++
 tb/tb_nx_fifo_rd_prefetch.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nx_fifo_rd_prefetch.sv
// Read-side prefetch for nx_fifo_ctrl: pops the FIFO and presents entries as a valid/ready stream.
// Latency: fifo_ren -> out_valid is RD_LATENCY+1 cycles. Back-pressure is absorbed by a DEPTH-entry credit-checked buffer.
// Optional stall counter: define NX_FIFO_RD_PREFETCH_PERF_EN to add the stall_cnt output.
module nx_fifo_rd_prefetch #(
    parameter int WIDTH      = 32,
    parameter int RD_LATENCY = 1,
    parameter int DEPTH      = 4,
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             fifo_empty,
    output logic             fifo_ren,
    input  logic [WIDTH-1:0] ram_rdata,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    out_count,
`ifdef NX_FIFO_RD_PREFETCH_PERF_EN
    output logic [15:0]      stall_cnt,
`endif
    output logic             underflow
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0]      buf_mem [DEPTH];
    logic [PW-1:0]         head;
    logic [PW-1:0]         tail;
    logic [RD_LATENCY-1:0] pipe;
    logic [CW-1:0]         inflight;
    logic                  cap;
    logic                  pop;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + CW'(pipe[i]);
        end
    end

    // Credit check ignores a same-cycle pop so there is no path from out_ready to fifo_ren.
    assign fifo_ren  = !rst && !fifo_empty && !clear &&
                       (({1'b0, out_count} + {1'b0, inflight}) < (CW + 1)'(DEPTH));
    assign out_valid = (out_count != '0);
    assign out_data  = buf_mem[head];
    assign cap       = pipe[RD_LATENCY-1] && !clear;
    assign pop       = out_valid && out_ready && !clear;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe      <= '0;
            head      <= '0;
            tail      <= '0;
            out_count <= '0;
            underflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_mem[i] <= '0;
            end
        end else begin
            underflow <= fifo_ren && fifo_empty;
            if (clear) begin
                // Squashed reads lose their tags, so late RAM beats are never captured.
                pipe      <= '0;
                head      <= '0;
                tail      <= '0;
                out_count <= '0;
            end else begin
                pipe <= (pipe << 1) | RD_LATENCY'(fifo_ren);
                if (cap) begin
                    buf_mem[tail] <= ram_rdata;
                    tail          <= wrap_inc(tail);
                end
                if (pop) begin
                    head <= wrap_inc(head);
                end
                case ({cap, pop})
                    2'b10:   out_count <= out_count + 1'b1;
                    2'b01:   out_count <= out_count - 1'b1;
                    default: out_count <= out_count;
                endcase
            end
        end
    end

    always @(posedge clk) begin
        if (!rst && cap && !pop) begin
            assert (out_count < CW'(DEPTH));
        end
    end

`ifdef NX_FIFO_RD_PREFETCH_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (clear) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_nx_fifo_rd_prefetch.sv
// Bench for nx_fifo_rd_prefetch: vector table, stream/clear sequences and a randomized run against a reference model.
module tb_nx_fifo_rd_prefetch;

    localparam int ML = 2;
    localparam int MD = 4;
    localparam int WL = 2;
    localparam int WD = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance: RD_LATENCY=2, DEPTH=4
    logic        m_rst = 1'b1;
    logic        m_clear = 1'b0;
    logic        m_empty, m_ren, m_valid, m_under;
    logic        m_ready = 1'b0;
    logic [31:0] m_rdata, m_data;
    logic [2:0]  m_count;
    // Wrap instance: RD_LATENCY=2, DEPTH=3
    logic        w_rst = 1'b1;
    logic        w_clear = 1'b0;
    logic        w_empty, w_ren, w_valid, w_under;
    logic        w_ready = 1'b0;
    logic [31:0] w_rdata, w_data;
    logic [1:0]  w_count;
`ifdef NX_FIFO_RD_PREFETCH_PERF_EN
    logic [15:0] m_stall, w_stall;
`endif

    nx_fifo_rd_prefetch #(.WIDTH(32), .RD_LATENCY(ML), .DEPTH(MD)) u_main (
        .clk(clk), .rst(m_rst), .clear(m_clear), .fifo_empty(m_empty), .fifo_ren(m_ren),
        .ram_rdata(m_rdata), .out_valid(m_valid), .out_ready(m_ready), .out_data(m_data),
        .out_count(m_count),
`ifdef NX_FIFO_RD_PREFETCH_PERF_EN
        .stall_cnt(m_stall),
`endif
        .underflow(m_under)
    );

    nx_fifo_rd_prefetch #(.WIDTH(32), .RD_LATENCY(WL), .DEPTH(WD)) u_wrap (
        .clk(clk), .rst(w_rst), .clear(w_clear), .fifo_empty(w_empty), .fifo_ren(w_ren),
        .ram_rdata(w_rdata), .out_valid(w_valid), .out_ready(w_ready), .out_data(w_data),
        .out_count(w_count),
`ifdef NX_FIFO_RD_PREFETCH_PERF_EN
        .stall_cnt(w_stall),
`endif
        .underflow(w_under)
    );

    // FIFO controller + RAM models: data appears RD_LATENCY cycles after fifo_ren.
    logic [31:0] m_mem [0:255];
    int          m_wr = 0;
    int          m_rd;
    logic [31:0] m_rp [ML];
    assign m_empty = (m_wr == m_rd);
    assign m_rdata = m_rp[ML-1];
    always @(posedge clk) begin
        if (m_clear) m_rd <= m_wr;
        else if (m_ren) m_rd <= m_rd + 1;
        m_rp[0] <= m_ren ? m_mem[m_rd] : 32'hDEAD_BEEF;
        for (int i = 1; i < ML; i++) m_rp[i] <= m_rp[i-1];
    end

    logic [31:0] w_mem [0:1023];
    int          w_wr = 0;
    int          w_rd;
    logic [31:0] w_rp [WL];
    assign w_empty = (w_wr == w_rd);
    assign w_rdata = w_rp[WL-1];
    always @(posedge clk) begin
        if (w_clear) w_rd <= w_wr;
        else if (w_ren) w_rd <= w_rd + 1;
        w_rp[0] <= w_ren ? w_mem[w_rd] : 32'hBAD0_0BAD;
        for (int i = 1; i < WL; i++) w_rp[i] <= w_rp[i-1];
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic rdy;
        logic ren;
        logic vld;
        int   cnt;
        int   dat;   // -1: data not checked
    } vec_t;
    vec_t tbl [18];

    logic [31:0] got [$];
    int first_ren, first_val, last_val, found;
    int cyc, exp_idx, pushed, popped, cap_total, infl, exp_cnt;
    logic exp_ren, exp_vld;
    bit hist [0:20099];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Back-pressure then drain of 10 entries (0x100..0x109) straight after reset release.
        tbl[0]  = '{1'b0, 1'b1, 1'b0, 0, -1};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 0, -1};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 0, -1};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 1, 32'h100};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 2, 32'h100};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 3, 32'h100};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 4, 32'h100};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 4, 32'h100};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 3, 32'h101};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 2, 32'h102};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 1, 32'h103};
        tbl[11] = '{1'b1, 1'b1, 1'b1, 1, 32'h104};
        tbl[12] = '{1'b1, 1'b1, 1'b1, 1, 32'h105};
        tbl[13] = '{1'b1, 1'b1, 1'b1, 1, 32'h106};
        tbl[14] = '{1'b1, 1'b0, 1'b1, 1, 32'h107};
        tbl[15] = '{1'b1, 1'b0, 1'b1, 1, 32'h108};
        tbl[16] = '{1'b1, 1'b0, 1'b1, 1, 32'h109};
        tbl[17] = '{1'b1, 1'b0, 1'b0, 0, -1};

        // Reset with a non-empty FIFO
        for (int i = 0; i < 10; i++) begin
            m_mem[m_wr] = 32'h100 + i;
            m_wr++;
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("rst_ren", m_ren, 0);
            chk("rst_valid", m_valid, 0);
            chk("rst_count", m_count, 0);
            chk("rst_data", m_data, 0);
            chk("rst_underflow", m_under, 0);
        end

        @(negedge clk);
        m_rst = 1'b0;
        for (int r = 0; r < 18; r++) begin
            m_ready = tbl[r].rdy;
            #1;
            chk($sformatf("vec%0d_ren", r), m_ren, tbl[r].ren);
            chk($sformatf("vec%0d_valid", r), m_valid, tbl[r].vld);
            chk($sformatf("vec%0d_count", r), m_count, tbl[r].cnt);
            chk($sformatf("vec%0d_underflow", r), m_under, 0);
            if (tbl[r].dat >= 0) chk($sformatf("vec%0d_data", r), m_data, tbl[r].dat);
            @(negedge clk);
        end

        // Stream: 8 entries with continuous out_ready
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            m_mem[m_wr] = 32'h10 + i;
            m_wr++;
        end
        first_ren = -1; first_val = -1; last_val = -1;
        got.delete();
        for (int c = 0; c < 20; c++) begin
            #1;
            if (m_ren && first_ren < 0) first_ren = c;
            if (m_valid) begin
                if (first_val < 0) first_val = c;
                last_val = c;
                got.push_back(m_data);
            end
            @(negedge clk);
        end
        chk("stream_first_ren", first_ren, 0);
        chk("stream_latency", first_val - first_ren, 3);
        chk("stream_consecutive", last_val - first_val, 7);
        chk("stream_n", got.size(), 8);
        for (int i = 0; i < 8 && i < got.size(); i++) chk($sformatf("stream_data%0d", i), got[i], 32'h10 + i);

        // Clear with 2 buffered and 2 in flight
        m_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            m_mem[m_wr] = 32'h200 + i;
            m_wr++;
        end
        found = -1;
        for (int c = 0; c < 20 && found < 0; c++) begin
            #1;
            if (m_count == 2 && !m_ren) found = c;
            else @(negedge clk);
        end
        chk("clr_reach_cycle", found, 4);
        m_clear = 1'b1;
        m_ready = 1'b1;
        #1;
        chk("clr_ren", m_ren, 0);
        @(negedge clk);
        m_clear = 1'b0;
        m_ready = 1'b0;
        #1;
        chk("clr_valid", m_valid, 0);
        chk("clr_count", m_count, 0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); #1;
            chk("clr_late_count", m_count, 0);
            chk("clr_late_ren", m_ren, 0);
        end
        @(negedge clk);
        m_ready = 1'b1;
        m_mem[m_wr] = 32'h300; m_wr++;
        m_mem[m_wr] = 32'h301; m_wr++;
        got.delete();
        for (int c = 0; c < 12; c++) begin
            #1;
            if (m_valid) got.push_back(m_data);
            @(negedge clk);
        end
        chk("post_clr_n", got.size(), 2);
        if (got.size() == 2) begin
            chk("post_clr_d0", got[0], 32'h300);
            chk("post_clr_d1", got[1], 32'h301);
        end

        // Randomized run on DEPTH=3 against a reference model
        w_rst = 1'b0;
        cyc = 0; exp_idx = 0; pushed = 0; popped = 0; cap_total = 0;
        while (exp_idx < 1000 && cyc < 20000) begin
            if (pushed < 1000 && $urandom_range(0, 3) != 0) begin
                w_mem[w_wr] = $urandom;
                w_wr++;
                pushed++;
            end
            w_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (cyc - WL - 1 >= 0) cap_total += int'(hist[cyc-WL-1]);
            infl = 0;
            for (int k = 1; k <= WL; k++) if (cyc - k >= 0) infl += int'(hist[cyc-k]);
            exp_cnt = cap_total - popped;
            exp_vld = (exp_cnt != 0);
            exp_ren = !w_empty && (exp_cnt + infl < WD);
            hist[cyc] = exp_ren;
            chk("rnd_ren", w_ren, exp_ren);
            chk("rnd_count", w_count, exp_cnt);
            chk("rnd_valid", w_valid, exp_vld);
            chk("rnd_underflow", w_under, 0);
            if (exp_vld && w_ready) begin
                chk($sformatf("rnd_data%0d", exp_idx), w_data, w_mem[exp_idx]);
                exp_idx++;
                popped++;
            end
            @(negedge clk);
            cyc++;
        end
        chk("rnd_drained", exp_idx, 1000);

`ifdef NX_FIFO_RD_PREFETCH_PERF_EN
        m_ready = 1'b0;
        m_mem[m_wr] = 32'h400; m_wr++;
        found = 0;
        for (int c = 0; c < 10 && !found; c++) begin
            #1;
            if (m_valid) found = 1;
            else @(negedge clk);
        end
        chk("perf_valid", found, 1);
        chk("perf_start", m_stall, 0);
        repeat (5) @(negedge clk);
        #1;
        chk("perf_stall5", m_stall, 5);
        m_clear = 1'b1;
        @(negedge clk);
        m_clear = 1'b0;
        #1;
        chk("perf_clear", m_stall, 0);
        m_mem[m_wr] = 32'h401; m_wr++;
        repeat (70000) @(negedge clk);
        #1;
        chk("perf_saturate", m_stall, 16'hFFFF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
